// File: rtl/mtimer_clint.sv
// Machine timer / software interrupt block: shared mtime, N_CH compare channels.
// Optional MTIMER_SNAPSHOT_EN: tear-free 64-bit mtime read via a hi-half shadow.
module mtimer_clint #(
   parameter int unsigned N_CH         = 1,
   parameter int unsigned PRESCALE_DIV = 1,
   parameter logic [63:0] MTIMECMP_RST = '1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            bus_req_i,
   input  logic            bus_we_i,
   input  logic [15:0]     bus_addr_i,
   input  logic [31:0]     bus_wdata_i,
   output logic [31:0]     bus_rdata_o,
   output logic            bus_rvalid_o,
   output logic            bus_err_o,
   input  logic            halt_i,
   output logic [N_CH-1:0] mtip_o,
   output logic [N_CH-1:0] msip_o
);

   logic [63:0]     mtime;
   logic [15:0]     pre;
   logic [63:0]     cmp [N_CH];
   logic [N_CH-1:0] msip;

   logic [13:0] wa;
   logic        rd, wr, tick;
   logic        msip_hit, cmp_hit, time_hit, hit;
   logic [3:0]  msip_idx, cmp_idx;
   logic        cmp_hi, time_hi;
   logic [31:0] rd_val, time_hi_rd;
   logic        unused_addr;

   assign wa          = bus_addr_i[15:2];
   assign unused_addr = ^bus_addr_i[1:0];
   assign rd          = bus_req_i && !bus_we_i;
   assign wr          = bus_req_i && bus_we_i;

   assign msip_hit = wa < 14'(N_CH);
   assign msip_idx = wa[3:0];
   assign cmp_hit  = (wa >= 14'h1000) && (wa < 14'h1000 + 14'(2 * N_CH));
   assign cmp_idx  = wa[4:1];
   assign cmp_hi   = wa[0];
   assign time_hit = wa[13:1] == 13'h17FF;
   assign time_hi  = wa[0];
   assign hit      = msip_hit || cmp_hit || time_hit;

   assign tick   = !halt_i && (pre == 16'(PRESCALE_DIV - 1));
   assign msip_o = msip;

`ifdef MTIMER_SNAPSHOT_EN
   logic [31:0] shadow;

   // Lo read captures hi so a following hi read cannot tear across a carry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (rd && time_hit && !time_hi) begin
         shadow <= mtime[63:32];
      end else if (wr && time_hit && time_hi) begin
         shadow <= bus_wdata_i;
      end
   end

   assign time_hi_rd = shadow;
`else
   assign time_hi_rd = mtime[63:32];
`endif

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (msip_hit && msip_idx == 4'(i)) rd_val = {31'b0, msip[i]};
         if (cmp_hit && cmp_idx == 4'(i))
            rd_val = cmp_hi ? cmp[i][63:32] : cmp[i][31:0];
      end
      if (time_hit) rd_val = time_hi ? time_hi_rd : mtime[31:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime        <= '0;
         pre          <= '0;
         msip         <= '0;
         mtip_o       <= '0;
         bus_rdata_o  <= '0;
         bus_rvalid_o <= 1'b0;
         bus_err_o    <= 1'b0;
         for (int i = 0; i < N_CH; i++) cmp[i] <= MTIMECMP_RST;
      end else begin
         if (!halt_i) pre <= tick ? '0 : pre + 16'd1;

         // A bus write to either half suppresses that cycle's increment
         if (wr && time_hit) begin
            if (time_hi) mtime[63:32] <= bus_wdata_i;
            else         mtime[31:0]  <= bus_wdata_i;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         for (int i = 0; i < N_CH; i++) begin
            if (wr && cmp_hit && cmp_idx == 4'(i)) begin
               if (cmp_hi) cmp[i][63:32] <= bus_wdata_i;
               else        cmp[i][31:0]  <= bus_wdata_i;
            end
            if (wr && msip_hit && msip_idx == 4'(i)) msip[i] <= bus_wdata_i[0];
            mtip_o[i] <= mtime >= cmp[i];
         end

         bus_rvalid_o <= rd;
         bus_err_o    <= bus_req_i && !hit;
         bus_rdata_o  <= rd ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_mtimer_clint.sv
// Bench for mtimer_clint: directed steps plus random traffic against
// an arithmetic model (mtime = base + ticks elapsed since last write).
module tb_mtimer_clint;

   localparam int NCH = 2;
   localparam int DIV = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           bus_req_i = 1'b0;
   logic           bus_we_i = 1'b0;
   logic [15:0]    bus_addr_i = '0;
   logic [31:0]    bus_wdata_i = '0;
   logic [31:0]    bus_rdata_o;
   logic           bus_rvalid_o;
   logic           bus_err_o;
   logic           halt_i = 1'b0;
   logic [NCH-1:0] mtip_o;
   logic [NCH-1:0] msip_o;

   mtimer_clint #(
      .N_CH(NCH),
      .PRESCALE_DIV(DIV)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus_req_i(bus_req_i),
      .bus_we_i(bus_we_i),
      .bus_addr_i(bus_addr_i),
      .bus_wdata_i(bus_wdata_i),
      .bus_rdata_o(bus_rdata_o),
      .bus_rvalid_o(bus_rvalid_o),
      .bus_err_o(bus_err_o),
      .halt_i(halt_i),
      .mtip_o(mtip_o),
      .msip_o(msip_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: active-cycle count since reset; mtime derived from last write point
   longint unsigned act, abase;
   logic [63:0]     m_base;
   logic [63:0]     m_cmp [NCH];
   logic [NCH-1:0]  m_msip, e_mtip;
   logic [31:0]     m_sh, e_rd;
   logic            e_rv, e_err;

   function automatic logic [63:0] mt();
      return m_base + 64'(act / DIV) - 64'(abase / DIV);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [63:0] cur;
      logic [31:0] rv;
      logic        mapped, rd, wr;
      int          ch;
      if (!rst_n) begin
         act = 0; abase = 0; m_base = '0; m_sh = '0;
         m_msip = '0; e_mtip = '0; e_rv = 0; e_err = 0; e_rd = '0;
         for (int i = 0; i < NCH; i++) m_cmp[i] = '1;
      end else begin
         cur = mt();
         for (int i = 0; i < NCH; i++) e_mtip[i] = cur >= m_cmp[i];
         rd = bus_req_i && !bus_we_i;
         wr = bus_req_i && bus_we_i;
         if (!halt_i) act++;
         mapped = 1'b1;
         rv = '0;
         if (bus_addr_i < 16'(4 * NCH)) begin
            ch = int'(bus_addr_i) / 4;
            rv = {31'b0, m_msip[ch]};
            if (wr) m_msip[ch] = bus_wdata_i[0];
         end else if (bus_addr_i >= 16'h4000 && bus_addr_i < 16'h4000 + 16'(8 * NCH)) begin
            ch = (int'(bus_addr_i) - 'h4000) / 8;
            rv = bus_addr_i[2] ? m_cmp[ch][63:32] : m_cmp[ch][31:0];
            if (wr && bus_addr_i[2]) m_cmp[ch][63:32] = bus_wdata_i;
            if (wr && !bus_addr_i[2]) m_cmp[ch][31:0] = bus_wdata_i;
         end else if (bus_addr_i == 16'hBFF8) begin
            rv = cur[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            if (rd) m_sh = cur[63:32];
`endif
            if (wr) begin m_base = {cur[63:32], bus_wdata_i}; abase = act; end
         end else if (bus_addr_i == 16'hBFFC) begin
`ifdef MTIMER_SNAPSHOT_EN
            rv = m_sh;
            if (wr) m_sh = bus_wdata_i;
`else
            rv = cur[63:32];
`endif
            if (wr) begin m_base = {bus_wdata_i, cur[31:0]}; abase = act; end
         end else begin
            mapped = 1'b0;
         end
         e_rv  = rd;
         e_err = bus_req_i && !mapped;
         e_rd  = rd ? rv : '0;
      end
      @(posedge clk);
      #1;
      chk("mtip", 64'(mtip_o), 64'(e_mtip));
      chk("msip", 64'(msip_o), 64'(m_msip));
      chk("rvalid", 64'(bus_rvalid_o), 64'(e_rv));
      chk("err", 64'(bus_err_o), 64'(e_err));
      if (e_rv) chk("rdata", 64'(bus_rdata_o), 64'(e_rd));
   endtask

   task automatic idle(int n);
      bus_req_i = 1'b0;
      bus_we_i = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(logic [15:0] a, logic [31:0] d);
      bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = a; bus_wdata_i = d;
      step();
      bus_req_i = 1'b0; bus_we_i = 1'b0;
   endtask

   task automatic rd(logic [15:0] a);
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = a;
      step();
      bus_req_i = 1'b0;
   endtask

   initial begin
      logic [15:0] addrs [11];
      logic [31:0] d;
      logic [15:0] a;
      addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h5000};

      rst_n = 1'b0;
      repeat (2) step();
      chk("rst_mtip", 64'(mtip_o), 64'd0);
      chk("rst_msip", 64'(msip_o), 64'd0);
      rst_n = 1'b1;

      idle(40);
      rd(16'hBFF8);
      chk("lo_after_40", 64'(bus_rdata_o), 64'd10);

      wr(16'h400C, 32'h0);
      wr(16'h4008, 32'd20);
      idle(80);
      chk("mtip1_set", 64'(mtip_o), 64'b10);
      wr(16'h400C, 32'h1);
      idle(2);
      chk("mtip1_clr", 64'(mtip_o), 64'b00);

      wr(16'h0000, 32'h1);
      wr(16'h0004, 32'hFFFF_FFFF);
      rd(16'h0004);
      wr(16'h0004, 32'h0);
      wr(16'h0008, 32'h1);
      chk("unmapped_wr_msip", 64'(msip_o), 64'b01);
      rd(16'h5000);
      chk("unmapped_rd_err", 64'(bus_err_o), 64'd1);
      chk("unmapped_rd_data", 64'(bus_rdata_o), 64'd0);

      wr(16'h4004, 32'h0);
      wr(16'h4000, 32'h0);
      wr(16'hBFF8, 32'hFFFF_FFFF);
      wr(16'hBFFC, 32'hFFFF_FFFF);
      idle(6);
      rd(16'hBFFC);
      chk("wrap_hi", 64'(bus_rdata_o), 64'd0);
      rd(16'hBFF8);

      wr(16'hBFFC, 32'h0);
      wr(16'hBFF8, 32'hFFFF_FFFF);
      rd(16'hBFF8);
      idle(5);
      rd(16'hBFFC);
`ifdef MTIMER_SNAPSHOT_EN
      chk("carry_hi", 64'(bus_rdata_o), 64'd0);
`else
      chk("carry_hi", 64'(bus_rdata_o), 64'd1);
`endif

      halt_i = 1'b1;
      rd(16'hBFF8);
      idle(20);
      wr(16'h0000, 32'h0);
      wr(16'h0000, 32'h1);
      chk("halt_msip", 64'(msip_o), 64'b01);
      idle(28);
      rd(16'hBFF8);
      wr(16'hBFF8, 32'd500);
      rd(16'hBFF8);
      chk("halt_time_wr", 64'(bus_rdata_o), 64'd500);
      halt_i = 1'b0;

      for (int n = 0; n < 600; n++) begin
         a = addrs[$urandom_range(0, 10)];
         d = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 700));
         if (a[2] && a >= 16'h4000) d = 32'($urandom_range(0, 1));
         bus_req_i   = $urandom_range(0, 2) != 0;
         bus_we_i    = $urandom_range(0, 1) == 1;
         bus_addr_i  = a;
         bus_wdata_i = d;
         halt_i      = $urandom_range(0, 5) == 0;
         rst_n       = $urandom_range(0, 80) != 0;
         step();
      end
      rst_n = 1'b1;
      halt_i = 1'b0;

      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 16'hBFF8;
      step();
      wr(16'h0000, 32'h1);
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 16'h0000;
      rst_n = 1'b0;
      step();
      chk("midrst_rvalid", 64'(bus_rvalid_o), 64'd0);
      chk("midrst_msip", 64'(msip_o), 64'd0);
      chk("midrst_mtip", 64'(mtip_o), 64'd0);
      chk("midrst_rdata", 64'(bus_rdata_o), 64'd0);
      rst_n = 1'b1;
      bus_req_i = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
